s2mm_pattern_gen: RTL and testbench
===================================

# s2mm_pattern_gen

Role-side AXI-Stream source feeding the AXI DMA S2MM channel (`axis_adma_s2mm`) of the zedboard basic platform. Software configures packet length, packet count and seed through the user AXI-Lite window (`axil_user`), then starts it. The block emits deterministic counter-pattern packets with correct `tlast` framing, plus progress and back-pressure counters, for DMA bring-up and throughput measurement.

## Interface
- `DATA_WIDTH`, 64, stream data width in bits; must equal `AXI_DMA_S_DW`; multiple of 32.
- `CNT_WIDTH`, 32, width of length, count and statistics counters.
- `sys_clk`  in  1  sole clock; AXI-Lite and AXIS are synchronous to it.
- `perif_rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_axil`  axi_lite.slave  32-bit data, CHANNEL=1  register access.
- `m_axis`  axis.master  DATA_WIDTH, ID_WIDTH=6  packet output toward `s_axis_adma_s2mm`.

## Operation
- Register map, word-aligned offsets:
  - 0x00 CTRL (W): bit0 START, write 1 to pulse; bit1 ABORT, write 1 to pulse.
  - 0x04 STATUS (R): bit0 BUSY, bit1 DONE.
  - 0x08 PKT_LEN (RW): beats per packet; a value of 0 is treated as 1.
  - 0x0C PKT_NUM (RW): packets per run; 0 means run until ABORT.
  - 0x10 SEED (RW): first 32-bit pattern value.
  - 0x14 PKT_SENT (R): packets completed in the current or last run.
  - 0x18 STALL_CNT (R): cycles with `tvalid && !tready`; saturates at all-ones.
- Unmapped or read-only write addresses are ignored. Unmapped reads return 0. `bresp`/`rresp` are always OKAY.
- FSM states and transitions:
  - IDLE → SEND on START. On this transition: latch PKT_LEN, PKT_NUM, SEED into shadow copies; clear PKT_SENT, STALL_CNT, DONE.
  - SEND → IDLE after the final `tlast` handshake of a finite run; sets DONE.
  - SEND → STOP on ABORT.
  - STOP finishes the current packet; STOP → IDLE on its `tlast` handshake.
  - If ABORT arrives between packets (beat index 0), SEND → IDLE directly.
  - Abort never sets DONE.
- BUSY is 1 in SEND or STOP.
- START while BUSY is ignored. ABORT in IDLE is ignored.
- Writes to PKT_LEN, PKT_NUM, SEED while BUSY update the registers but not the running shadows.
- Pattern: 32-bit lane i of global beat b (counted from the start of the run, across packets) = SEED + b·(DATA_WIDTH/32) + i, modulo 2^32. Lane 0 is the least significant.
- `tkeep` is all ones. `tid` = 0. `tlast` is asserted on beat PKT_LEN−1 of each packet.
- PKT_SENT increments on each `tlast` handshake and wraps at 2^CNT_WIDTH.

## Timing
- Reset values:
  - AXI-Lite: `awready`, `wready`, `bvalid`, `arready`, `rvalid` = 0; `rdata` = 0.
  - AXIS: `tvalid`, `tlast` = 0; `tdata` = 0.
  - FSM in IDLE; all registers and counters 0.
- AXI-Lite write:
  - Accept AW and W independently; `awready`/`wready` drop once the respective channel is captured.
  - Register update happens in the cycle both are held.
  - `bvalid` follows 1 cycle later and holds until `bready`.
  - Only one write is outstanding.
- AXI-Lite read: `rvalid` follows the AR handshake by 1 cycle and holds until `rready`. `arready` stays low while `rvalid` is high.
- START latency: FSM enters SEND the cycle after the CTRL write takes effect. `tvalid` rises in that same SEND cycle.
- AXIS rules:
  - Once `tvalid` is high, `tdata`, `tlast`, `tvalid` stay stable until `tready`.
  - `tvalid` never deasserts mid-packet except on reset.
  - Full throughput: one beat per cycle while `tready` = 1.
  - Back-to-back packets have no gap.
- ABORT and final-`tlast` handshake in the same cycle: the run ends normally and DONE is set.
- Reset mid-packet: outputs return to reset values immediately; the truncated packet is the system's responsibility.

## Structure
- Package `s2mm_gen_pkg`: register offset localparams, CTRL/STATUS bit indices, FSM enum `gen_state_t` {IDLE, SEND, STOP}.
- Sub-module `s2mm_gen_regs`: AXI-Lite slave plus register file. It outputs START/ABORT pulses and config values, and takes status and counters as inputs.
- Top level: FSM, beat/packet counters, pattern datapath, stall counter.

## Test plan
- PKT_LEN=4, PKT_NUM=2, SEED=0x100, DATA_WIDTH=64, `tready` = 1 → 8 consecutive beats; lanes (0x100,0x101)…(0x10E,0x10F); `tlast` on beats 3 and 7; DONE=1; PKT_SENT=2.
- Same config with `tready` toggled by a random 50% pattern → identical beat sequence; no `tdata` change while stalled; STALL_CNT = number of stalled cycles.
- PKT_NUM=0, PKT_LEN=3; ABORT written mid-packet at beat 1 → beat 2 is sent with `tlast`, then IDLE; DONE=0; BUSY=0.
- PKT_LEN=0, PKT_NUM=3 → three single-beat packets, each with `tlast`=1.
- START written while BUSY, and PKT_LEN rewritten while BUSY → run unaffected; readback shows the new PKT_LEN.
- `perif_rst_n` asserted at beat 2 of 5 → `tvalid` = 0 immediately; all registers read 0 after release; a subsequent START runs cleanly.

Source files
------------

// File: rtl/s2mm_gen_pkg.sv
// Shared constants, register map and FSM encoding for the S2MM pattern generator.
package s2mm_gen_pkg;

    localparam int unsigned AXIL_AW       = 32;
    localparam int unsigned AXIL_DW       = 32;
    localparam int unsigned AXIL_SW       = AXIL_DW / 8;
    localparam int unsigned AXIS_ID_WIDTH = 6;

    localparam logic [AXIL_AW-1:0] REG_CTRL      = 32'h0000_0000;
    localparam logic [AXIL_AW-1:0] REG_STATUS    = 32'h0000_0004;
    localparam logic [AXIL_AW-1:0] REG_PKT_LEN   = 32'h0000_0008;
    localparam logic [AXIL_AW-1:0] REG_PKT_NUM   = 32'h0000_000C;
    localparam logic [AXIL_AW-1:0] REG_SEED      = 32'h0000_0010;
    localparam logic [AXIL_AW-1:0] REG_PKT_SENT  = 32'h0000_0014;
    localparam logic [AXIL_AW-1:0] REG_STALL_CNT = 32'h0000_0018;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_ABORT_BIT = 1;
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_DONE_BIT  = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        STOP = 2'd2
    } gen_state_t;

    // Byte-lane merge of a write into an existing register value.
    function automatic logic [AXIL_DW-1:0] apply_strb(
        input logic [AXIL_DW-1:0] cur,
        input logic [AXIL_DW-1:0] wr,
        input logic [AXIL_SW-1:0] strb
    );
        logic [AXIL_DW-1:0] r;
        r = cur;
        for (int unsigned b = 0; b < AXIL_SW; b++) begin
            if (strb[b]) r[b*8 +: 8] = wr[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/s2mm_gen_regs.sv
// AXI-Lite slave and register file: config registers, START/ABORT pulses, status readback.
module s2mm_gen_regs
    import s2mm_gen_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AXIL_AW-1:0]   awaddr,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [AXIL_DW-1:0]   wdata,
    input  logic [AXIL_SW-1:0]   wstrb,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic [AXIL_AW-1:0]   araddr,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [AXIL_DW-1:0]   rdata,
    output logic [1:0]           rresp,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 start,
    output logic                 abort,
    output logic [CNT_WIDTH-1:0] pkt_len,
    output logic [CNT_WIDTH-1:0] pkt_num,
    output logic [31:0]          seed,
    input  logic                 busy,
    input  logic                 done,
    input  logic [CNT_WIDTH-1:0] pkt_sent,
    input  logic [CNT_WIDTH-1:0] stall_cnt
);

    logic [AXIL_AW-1:0] aw_addr_q;
    logic [AXIL_DW-1:0] w_data_q;
    logic [AXIL_SW-1:0] w_strb_q;
    logic               aw_full_q, aw_full_d;
    logic               w_full_q, w_full_d;
    logic               bvalid_d, rvalid_d;
    logic               awready_d, wready_d, arready_d;
    logic               wr_fire;
    logic [AXIL_DW-1:0] rd_val;

    assign bresp   = RESP_OKAY;
    assign rresp   = RESP_OKAY;
    assign wr_fire = aw_full_q && w_full_q;

    // Next-state of channel capture flags and ready/valid handshakes.
    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        bvalid_d  = bvalid;
        rvalid_d  = rvalid;
        if (awvalid && awready) aw_full_d = 1'b1;
        if (wvalid && wready)   w_full_d  = 1'b1;
        if (wr_fire) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else if (bvalid && bready) begin
            bvalid_d = 1'b0;
        end
        if (arvalid && arready)     rvalid_d = 1'b1;
        else if (rvalid && rready)  rvalid_d = 1'b0;
        // A single write in flight: no new address/data until the response is taken.
        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d && !bvalid_d;
        arready_d = !rvalid_d;
    end

    // Read data mux; write-only and unmapped offsets read as zero.
    always_comb begin
        rd_val = '0;
        case (araddr)
            REG_STATUS: begin
                rd_val[STAT_BUSY_BIT] = busy;
                rd_val[STAT_DONE_BIT] = done;
            end
            REG_PKT_LEN:   rd_val = AXIL_DW'(pkt_len);
            REG_PKT_NUM:   rd_val = AXIL_DW'(pkt_num);
            REG_SEED:      rd_val = seed;
            REG_PKT_SENT:  rd_val = AXIL_DW'(pkt_sent);
            REG_STALL_CNT: rd_val = AXIL_DW'(stall_cnt);
            default:       rd_val = '0;
        endcase
    end

    // Handshake registers and captured channel payloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            awready   <= awready_d;
            wready    <= wready_d;
            bvalid    <= bvalid_d;
            arready   <= arready_d;
            rvalid    <= rvalid_d;
            if (awvalid && awready) aw_addr_q <= awaddr;
            if (wvalid && wready) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (arvalid && arready) rdata <= rd_val;
        end
    end

    // Register file update and one-cycle control pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start   <= 1'b0;
            abort   <= 1'b0;
            pkt_len <= '0;
            pkt_num <= '0;
            seed    <= '0;
        end else begin
            start <= 1'b0;
            abort <= 1'b0;
            if (wr_fire) begin
                case (aw_addr_q)
                    REG_CTRL: begin
                        start <= w_strb_q[0] && w_data_q[CTRL_START_BIT];
                        abort <= w_strb_q[0] && w_data_q[CTRL_ABORT_BIT];
                    end
                    REG_PKT_LEN: pkt_len <= CNT_WIDTH'(apply_strb(AXIL_DW'(pkt_len), w_data_q, w_strb_q));
                    REG_PKT_NUM: pkt_num <= CNT_WIDTH'(apply_strb(AXIL_DW'(pkt_num), w_data_q, w_strb_q));
                    REG_SEED:    seed    <= apply_strb(seed, w_data_q, w_strb_q);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/s2mm_pattern_gen.sv
// Counter-pattern AXI-Stream packet source for DMA S2MM bring-up and throughput measurement.
module s2mm_pattern_gen
    import s2mm_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                     sys_clk,
    input  logic                     perif_rst_n,
    input  logic [AXIL_AW-1:0]       s_axil_awaddr,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [AXIL_DW-1:0]       s_axil_wdata,
    input  logic [AXIL_SW-1:0]       s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    input  logic [AXIL_AW-1:0]       s_axil_araddr,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [AXIL_DW-1:0]       s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [AXIS_ID_WIDTH-1:0] m_axis_tid
);

    localparam int unsigned LANES = DATA_WIDTH / 32;

    gen_state_t            state_q, state_d;
    logic                  start, abort, busy;
    logic [CNT_WIDTH-1:0]  cfg_len, cfg_num, cfg_len_eff;
    logic [31:0]           cfg_seed;
    logic [CNT_WIDTH-1:0]  len_sh_q, len_sh_d, num_sh_q, num_sh_d;
    logic [CNT_WIDTH-1:0]  beat_q, beat_d, beat_nx;
    logic [CNT_WIDTH-1:0]  pkt_sent_q, pkt_sent_d, pkt_sent_inc;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
    logic [31:0]           pat_q, pat_d, pat_nx;
    logic                  done_q, done_d;
    logic                  tvalid_d, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_d;
    logic                  hs, final_pkt, end_run;

    assign busy         = (state_q != IDLE);
    assign m_axis_tkeep = '1;
    assign m_axis_tid   = '0;

    s2mm_gen_regs #(.CNT_WIDTH(CNT_WIDTH)) u_regs (
        .clk       (sys_clk),
        .rst_n     (perif_rst_n),
        .awaddr    (s_axil_awaddr),
        .awvalid   (s_axil_awvalid),
        .awready   (s_axil_awready),
        .wdata     (s_axil_wdata),
        .wstrb     (s_axil_wstrb),
        .wvalid    (s_axil_wvalid),
        .wready    (s_axil_wready),
        .bresp     (s_axil_bresp),
        .bvalid    (s_axil_bvalid),
        .bready    (s_axil_bready),
        .araddr    (s_axil_araddr),
        .arvalid   (s_axil_arvalid),
        .arready   (s_axil_arready),
        .rdata     (s_axil_rdata),
        .rresp     (s_axil_rresp),
        .rvalid    (s_axil_rvalid),
        .rready    (s_axil_rready),
        .start     (start),
        .abort     (abort),
        .pkt_len   (cfg_len),
        .pkt_num   (cfg_num),
        .seed      (cfg_seed),
        .busy      (busy),
        .done      (done_q),
        .pkt_sent  (pkt_sent_q),
        .stall_cnt (stall_q)
    );

    // One beat of consecutive 32-bit lane values, lane 0 in the low bits.
    function automatic logic [DATA_WIDTH-1:0] make_beat(input logic [31:0] base);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < LANES; i++) d[i*32 +: 32] = base + 32'(i);
        return d;
    endfunction

    // FSM state register.
    always_ff @(posedge sys_clk or negedge perif_rst_n) begin
        if (!perif_rst_n) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Next state plus next values of the beat, counter and output registers.
    always_comb begin
        state_d    = state_q;
        tvalid_d   = m_axis_tvalid;
        tdata_d    = m_axis_tdata;
        tlast_d    = m_axis_tlast;
        beat_d     = beat_q;
        pat_d      = pat_q;
        pkt_sent_d = pkt_sent_q;
        stall_d    = stall_q;
        done_d     = done_q;
        len_sh_d   = len_sh_q;
        num_sh_d   = num_sh_q;
        end_run    = 1'b0;

        hs           = m_axis_tvalid && m_axis_tready;
        pkt_sent_inc = pkt_sent_q + CNT_WIDTH'(1);
        final_pkt    = (num_sh_q != '0) && (pkt_sent_inc == num_sh_q);
        beat_nx      = m_axis_tlast ? '0 : beat_q + CNT_WIDTH'(1);
        pat_nx       = pat_q + 32'(LANES);
        cfg_len_eff  = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;

        if (m_axis_tvalid && !m_axis_tready && (stall_q != '1)) stall_d = stall_q + CNT_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND;
                    len_sh_d   = cfg_len_eff;
                    num_sh_d   = cfg_num;
                    pat_d      = cfg_seed;
                    beat_d     = '0;
                    tvalid_d   = 1'b1;
                    tdata_d    = make_beat(cfg_seed);
                    tlast_d    = (cfg_len_eff == CNT_WIDTH'(1));
                    pkt_sent_d = '0;
                    stall_d    = '0;
                    done_d     = 1'b0;
                end
            end
            SEND, STOP: begin
                if (hs && m_axis_tlast) begin
                    pkt_sent_d = pkt_sent_inc;
                    // Completion wins over a coincident abort; an abort landing on a
                    // packet boundary ends the run without starting another packet.
                    if ((state_q == SEND) && final_pkt) begin
                        done_d  = 1'b1;
                        end_run = 1'b1;
                    end else if ((state_q == STOP) || abort) begin
                        end_run = 1'b1;
                    end
                end
                if (end_run) begin
                    state_d  = IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    tdata_d  = '0;
                end else begin
                    if (hs) begin
                        beat_d  = beat_nx;
                        pat_d   = pat_nx;
                        tdata_d = make_beat(pat_nx);
                        tlast_d = (beat_nx == (len_sh_q - CNT_WIDTH'(1)));
                    end
                    // A presented beat is never withdrawn, so abort drains the packet.
                    if ((state_q == SEND) && abort) state_d = STOP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath, counters and AXIS output registers.
    always_ff @(posedge sys_clk or negedge perif_rst_n) begin
        if (!perif_rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            beat_q        <= '0;
            pat_q         <= '0;
            pkt_sent_q    <= '0;
            stall_q       <= '0;
            done_q        <= 1'b0;
            len_sh_q      <= '0;
            num_sh_q      <= '0;
        end else begin
            m_axis_tvalid <= tvalid_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tlast  <= tlast_d;
            beat_q        <= beat_d;
            pat_q         <= pat_d;
            pkt_sent_q    <= pkt_sent_d;
            stall_q       <= stall_d;
            done_q        <= done_d;
            len_sh_q      <= len_sh_d;
            num_sh_q      <= num_sh_d;
        end
    end

endmodule

// File: tb/tb_s2mm_pattern_gen.sv
// Directed-plus-random bench for s2mm_pattern_gen against an arithmetic pattern model.
module tb_s2mm_pattern_gen;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_LEN    = 32'h08;
    localparam logic [31:0] A_NUM    = 32'h0C;
    localparam logic [31:0] A_SEED   = 32'h10;
    localparam logic [31:0] A_SENT   = 32'h14;
    localparam logic [31:0] A_STALL  = 32'h18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        tvalid, tready, tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [5:0]  tid;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t q[$];
    int    tests = 0;
    int    fails = 0;
    int    stalls = 0;
    int    viol = 0;
    int    ncyc = 0;
    logic  rdy_rand = 1'b0;

    always #5 clk = ~clk;

    s2mm_pattern_gen #(.DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
        .sys_clk        (clk),
        .perif_rst_n    (rst_n),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tdata   (tdata),
        .m_axis_tkeep   (tkeep),
        .m_axis_tlast   (tlast),
        .m_axis_tid     (tid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random back-pressure source when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) tready = 1'($urandom_range(0, 1));
        end
    end

    // Stream monitor: handshakes, stall cycles, and stability of stalled or mid-packet beats.
    initial begin
        logic        prev_stall, prev_mid, prev_last;
        logic [63:0] prev_data;
        prev_stall = 1'b0;
        prev_mid   = 1'b0;
        prev_last  = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_mid   = 1'b0;
            end else begin
                if ((prev_stall || prev_mid) && !tvalid) viol++;
                if (prev_stall && ((tdata !== prev_data) || (tlast !== prev_last))) viol++;
                if (tvalid && tready) q.push_back('{tdata, tlast, ncyc});
                if (tvalid && !tready) stalls++;
                prev_stall = tvalid && !tready;
                prev_mid   = tvalid && tready && !tlast;
                prev_data  = tdata;
                prev_last  = tlast;
            end
        end
    end

    task automatic axil_write(input logic [31:0] a, input logic [31:0] d);
        int  n;
        logic aw_now, w_now, b_now;
        awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            step();
            if (aw_now) awvalid = 1'b0;
            if (w_now)  wvalid  = 1'b0;
            n++;
        end
        bready = 1'b1;
        while (n < 50) begin
            b_now = bvalid;
            step();
            n++;
            if (b_now) break;
        end
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("axil_wr_timeout", 64'(n >= 50), 64'(0));
    endtask

    task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
        int   n;
        logic ar_now;
        araddr = a; arvalid = 1'b1; d = '0;
        n = 0;
        while (n < 50) begin
            ar_now = arready;
            step();
            n++;
            if (ar_now) break;
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        while (n < 50) begin
            if (rvalid) begin
                d = rdata;
                step();
                break;
            end
            step();
            n++;
        end
        rready = 1'b0;
        chk("axil_rd_timeout", 64'(n >= 50), 64'(0));
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axil_read(a, d);
        chk(tag, 64'(d), 64'(exp));
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st;
        int          k;
        k = 0;
        do begin
            axil_read(A_STATUS, st);
            k++;
        end while (st[0] && k < 200);
        chk({tag, "_busy"}, 64'(st[0]), 64'(0));
    endtask

    task automatic wait_tvalid(input string tag);
        int k;
        k = 0;
        while (!tvalid && k < 20) begin
            step();
            k++;
        end
        chk({tag, "_tvalid"}, 64'(tvalid), 64'(1));
    endtask

    task automatic pass_beats(input int n);
        tready = 1'b1;
        repeat (n) step();
        tready = 1'b0;
    endtask

    task automatic configure(input logic [31:0] len, input logic [31:0] num, input logic [31:0] seed);
        axil_write(A_LEN, len);
        axil_write(A_NUM, num);
        axil_write(A_SEED, seed);
    endtask

    // Expected stream: lane i of global beat b is seed + 2*b + i; tlast every len_eff beats.
    task automatic chk_run(input string tag, input logic [31:0] seed, input int len_eff, input int nbeats);
        logic [63:0] exp;
        int          n;
        chk({tag, "_count"}, 64'(q.size()), 64'(nbeats));
        n = (q.size() < nbeats) ? q.size() : nbeats;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 2; i++) exp[i*32 +: 32] = seed + 32'(b * 2 + i);
            chk($sformatf("%s_data%0d", tag, b), q[b].data, exp);
            chk($sformatf("%s_last%0d", tag, b), 64'(q[b].last), 64'((b % len_eff) == (len_eff - 1)));
        end
    endtask

    task automatic clear_mon();
        q.delete();
        stalls = 0;
        viol   = 0;
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] d;

        rst_n = 1'b0; tready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state of every output.
        repeat (3) step();
        chk("rst_awready", 64'(awready), 0);
        chk("rst_wready",  64'(wready),  0);
        chk("rst_bvalid",  64'(bvalid),  0);
        chk("rst_arready", 64'(arready), 0);
        chk("rst_rvalid",  64'(rvalid),  0);
        chk("rst_rdata",   64'(rdata),   0);
        chk("rst_tvalid",  64'(tvalid),  0);
        chk("rst_tlast",   64'(tlast),   0);
        chk("rst_tdata",   tdata,        0);
        rst_n = 1'b1;
        step();
        rd_chk("rst_status", A_STATUS, 0);
        rd_chk("rst_len",    A_LEN,    0);
        rd_chk("rst_seed",   A_SEED,   0);
        rd_chk("rst_stall",  A_STALL,  0);
        // Read-only and unmapped writes are dropped; unmapped reads give zero.
        axil_write(A_SENT, 32'hFFFF);
        axil_write(32'h40, 32'h1234);
        rd_chk("ro_sent",    A_SENT, 0);
        rd_chk("unmapped_rd", 32'h40, 0);

        // Basic run, full throughput.
        tready = 1'b1;
        configure(4, 2, 32'h100);
        clear_mon();
        axil_write(A_CTRL, 1);
        wait_idle("t2");
        chk_run("t2", 32'h100, 4, 8);
        for (int k = 1; k < q.size(); k++) chk($sformatf("t2_gap%0d", k), 64'(q[k].cyc - q[k-1].cyc), 1);
        chk("t2_tkeep", 64'(tkeep), 64'hFF);
        chk("t2_tid",   64'(tid),   0);
        rd_chk("t2_status", A_STATUS, 32'h2);
        rd_chk("t2_sent",   A_SENT,   2);
        rd_chk("t2_stall",  A_STALL,  0);

        // Same run under random back-pressure.
        clear_mon();
        rdy_rand = 1'b1;
        axil_write(A_CTRL, 1);
        wait_idle("t3");
        rdy_rand = 1'b0; tready = 1'b1;
        chk_run("t3", 32'h100, 4, 8);
        chk("t3_axis_rules", 64'(viol), 0);
        rd_chk("t3_stall", A_STALL, 32'(stalls));
        rd_chk("t3_sent",  A_SENT,  2);

        // Endless run aborted with beat 1 of 3 presented.
        s = $urandom;
        tready = 1'b0;
        configure(3, 0, s);
        clear_mon();
        axil_write(A_CTRL, 1);
        wait_tvalid("t4");
        pass_beats(1);
        axil_write(A_CTRL, 2);
        rd_chk("t4_busy_stop", A_STATUS, 32'h1);
        tready = 1'b1;
        wait_idle("t4");
        chk_run("t4", s, 3, 3);
        rd_chk("t4_status", A_STATUS, 0);
        rd_chk("t4_sent",   A_SENT,   1);
        chk("t4_axis_rules", 64'(viol), 0);

        // Zero length treated as one; seed chosen to wrap the 32-bit lanes.
        configure(0, 3, 32'hFFFF_FFFE);
        clear_mon();
        axil_write(A_CTRL, 1);
        wait_idle("t5");
        chk_run("t5", 32'hFFFF_FFFE, 1, 3);
        rd_chk("t5_sent",   A_SENT,   3);
        rd_chk("t5_status", A_STATUS, 32'h2);

        // START and PKT_LEN rewrite while busy leave the run untouched.
        s = $urandom;
        tready = 1'b0;
        configure(4, 3, s);
        clear_mon();
        axil_write(A_CTRL, 1);
        wait_tvalid("t6");
        axil_write(A_LEN, 7);
        axil_write(A_CTRL, 1);
        rd_chk("t6_len_rb", A_LEN, 7);
        rd_chk("t6_busy",   A_STATUS, 32'h1);
        rdy_rand = 1'b1;
        wait_idle("t6");
        rdy_rand = 1'b0; tready = 1'b1;
        chk_run("t6", s, 4, 12);
        rd_chk("t6_sent", A_SENT, 3);
        chk("t6_axis_rules", 64'(viol), 0);

        // Reset in the middle of a packet, then a clean run.
        tready = 1'b0;
        configure(5, 1, $urandom);
        clear_mon();
        axil_write(A_CTRL, 1);
        wait_tvalid("t7");
        pass_beats(2);
        chk("t7_pre_beats", 64'(q.size()), 2);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_tvalid", 64'(tvalid), 0);
        chk("t7_rst_tlast",  64'(tlast),  0);
        chk("t7_rst_tdata",  tdata,       0);
        step();
        rst_n = 1'b1;
        step();
        rd_chk("t7_len",    A_LEN,    0);
        rd_chk("t7_num",    A_NUM,    0);
        rd_chk("t7_seed",   A_SEED,   0);
        rd_chk("t7_sent",   A_SENT,   0);
        rd_chk("t7_stall",  A_STALL,  0);
        rd_chk("t7_status", A_STATUS, 0);
        s = $urandom;
        tready = 1'b1;
        configure(2, 2, s);
        clear_mon();
        axil_write(A_CTRL, 1);
        wait_idle("t7b");
        chk_run("t7b", s, 2, 4);
        axil_read(A_STATUS, d);
        chk("t7b_done", 64'(d[1]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
